// File: rtl/calc_pkg.sv
// Shared calculator types: operand word and ALU operation codes.
package calc_pkg;

    typedef logic [15:0] num_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_t;

endpackage

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one calculator ALU between NumReq requesters,
// one transaction in flight. Optional WAIT watchdog: define ALU_ARB_TIMEOUT_EN.
module alu_arbiter #(
    parameter int NumReq        = 2,
    parameter int IdxW          = (NumReq > 1) ? $clog2(NumReq) : 1,
    parameter int TimeoutCycles = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumReq-1:0]             req_valid_i,
    output logic [NumReq-1:0]             req_ready_o,
    input  calc_pkg::num_t [NumReq-1:0]   req_left_i,
    input  calc_pkg::num_t [NumReq-1:0]   req_right_i,
    input  calc_pkg::op_t  [NumReq-1:0]   req_op_i,
    output logic [NumReq-1:0]             rsp_valid_o,
    input  logic [NumReq-1:0]             rsp_ready_i,
    output calc_pkg::num_t                rsp_result_o,
    output logic                          rsp_error_o,
    output calc_pkg::num_t                alu_left_o,
    output calc_pkg::num_t                alu_right_o,
    output calc_pkg::op_t                 alu_op_o,
    output logic                          alu_in_valid_o,
    input  logic                          alu_in_ready_i,
    input  calc_pkg::num_t                alu_result_i,
    input  logic                          alu_out_valid_i,
    output logic                          alu_out_ready_o
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_RESPOND = 2'd3;

    if (NumReq < 1 || NumReq > 8 || TimeoutCycles < 1) begin : g_bad_cfg
        $error("alu_arbiter: unsupported NumReq/TimeoutCycles");
    end

    logic [1:0]      state;
    logic [IdxW-1:0] rr_ptr, owner, winner, cand, ptr_nxt;
    logic            any_req;
    int              idx;
    calc_pkg::num_t  left_q, right_q, result_q;
    calc_pkg::op_t   op_q;
    logic            tmo_hit;

    // Scan from rr_ptr upward with wrap; first valid requester wins.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        idx     = 0;
        cand    = '0;
        for (int i = 0; i < NumReq; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NumReq) idx = idx - NumReq;
            cand = IdxW'(idx);
            if (req_valid_i[cand] && !any_req) begin
                any_req = 1'b1;
                winner  = cand;
            end
        end
        ptr_nxt = (int'(winner) == NumReq - 1) ? '0 : winner + 1'b1;
    end

    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            req_ready_o[i] = rst_ni && (state == S_IDLE) && any_req && (winner == IdxW'(i));
            rsp_valid_o[i] = (state == S_RESPOND) && (owner == IdxW'(i));
        end
    end

    assign alu_in_valid_o  = (state == S_ISSUE);
    assign alu_out_ready_o = (state == S_WAIT);
    assign alu_left_o      = left_q;
    assign alu_right_o     = right_q;
    assign alu_op_o        = op_q;
    assign rsp_result_o    = result_q;

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles + 1);
    logic [CntW-1:0] tmo_cnt;
    logic            error_q;

    // Counter saturates at the limit; it restarts on every entry to WAIT.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt <= '0;
        end else if (state == S_ISSUE && alu_in_ready_i) begin
            tmo_cnt <= '0;
        end else if (state == S_WAIT && tmo_cnt != CntW'(TimeoutCycles)) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign tmo_hit     = (state == S_WAIT) && (tmo_cnt == CntW'(TimeoutCycles));
    assign rsp_error_o = error_q;
`else
    assign tmo_hit     = 1'b0;
    assign rsp_error_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            left_q   <= '0;
            right_q  <= '0;
            op_q     <= calc_pkg::OP_ADD;
            result_q <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
            error_q  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        left_q  <= req_left_i[winner];
                        right_q <= req_right_i[winner];
                        op_q    <= req_op_i[winner];
                        owner   <= winner;
                        rr_ptr  <= ptr_nxt;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (alu_in_ready_i) state <= S_WAIT;
                end
                S_WAIT: begin
                    // A result landing on the limit cycle takes priority over the timeout.
                    if (alu_out_valid_i) begin
                        result_q <= alu_result_i;
`ifdef ALU_ARB_TIMEOUT_EN
                        error_q  <= 1'b0;
`endif
                        state    <= S_RESPOND;
                    end else if (tmo_hit) begin
                        result_q <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
                        error_q  <= 1'b1;
`endif
                        state    <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    if (rsp_ready_i[owner]) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
